// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CLR  = 2'b01,
    ST_RUN  = 2'b10,
    ST_WB   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_t;

  localparam int CNT_W          = 6;
  localparam int MULT_MIN_DEF   = 33;
  localparam int DIV_MIN_DEF    = 33;
  localparam int MAX_CYCLES_DEF = 63;

endpackage

// File: rtl/muldiv_ctrl_hilo_regs.sv
// Architectural HI/LO pair: written by MULT/DIV writeback or by MTHI/MTLO.
module hilo_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  input  logic        mt_hi_we,
  input  logic        mt_lo_we,
  input  logic [31:0] mt_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (wb_we) begin
      hi <= wb_hi;
      lo <= wb_lo;
    end else begin
      if (mt_hi_we) hi <= mt_data;
      if (mt_lo_we) lo <= mt_data;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multiplier/divider: operand latch, unit reset/enable,
// stale-done qualification, watchdog, and HI/LO ownership.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_MIN   = MULT_MIN_DEF,
  parameter int DIV_MIN    = DIV_MIN_DEF,
  parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic [1:0]  op_sel,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mult_reset,
  output logic        mult_ctrl,
  input  logic        mult_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        div_reset,
  output logic        div_ctrl,
  input  logic        div_done,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout
);

  typedef logic [CNT_W:0] cnt_ext_t;
  localparam cnt_ext_t MULT_LIM = cnt_ext_t'(MULT_MIN);
  localparam cnt_ext_t DIV_LIM  = cnt_ext_t'(DIV_MIN);
  localparam cnt_ext_t MAX_LIM  = cnt_ext_t'(MAX_CYCLES);

  state_t           state;
  op_t              op;
  logic             unit_div;
  logic [CNT_W-1:0] cnt;
  cnt_ext_t         cnt_inc;
  cnt_ext_t         min_lim;
  logic             sel_done;
  logic             idle_start;

  assign op         = op_t'(op_sel);
  assign idle_start = (state == ST_IDLE) && op_start;
  // cnt_inc is the number of RUN cycles including the current one
  assign cnt_inc    = {1'b0, cnt} + cnt_ext_t'(1);
  assign min_lim    = unit_div ? DIV_LIM : MULT_LIM;
  assign sel_done   = unit_div ? div_done : mult_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      unit_div   <= 1'b0;
      cnt        <= '0;
      unit_a     <= '0;
      unit_b     <= '0;
      mult_reset <= 1'b0;
      mult_ctrl  <= 1'b0;
      div_reset  <= 1'b0;
      div_ctrl   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      done       <= 1'b0;
      div_zero   <= 1'b0;
      mult_reset <= 1'b0;
      div_reset  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (idle_start) begin
            if (op == OP_MULT || (op == OP_DIV && op_b != '0)) begin
              unit_a     <= op_a;
              unit_b     <= op_b;
              unit_div   <= (op == OP_DIV);
              mult_reset <= (op == OP_MULT);
              div_reset  <= (op == OP_DIV);
              timeout    <= 1'b0;
              busy       <= 1'b1;
              state      <= ST_CLR;
            end else if (op == OP_DIV) begin
              div_zero <= 1'b1;
            end
          end
        end
        ST_CLR: begin
          cnt       <= '0;
          mult_ctrl <= !unit_div;
          div_ctrl  <= unit_div;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          // a done seen before the minimum count is left over from the previous op
          if (sel_done && cnt_inc >= min_lim) begin
            mult_ctrl <= 1'b0;
            div_ctrl  <= 1'b0;
            state     <= ST_WB;
          end else if (cnt_inc >= MAX_LIM) begin
            mult_ctrl <= 1'b0;
            div_ctrl  <= 1'b0;
            timeout   <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            cnt <= (cnt_inc > MAX_LIM) ? cnt : cnt_inc[CNT_W-1:0];
          end
        end
        ST_WB: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  hilo_regs u_hilo (
    .clk      (clk),
    .reset    (reset),
    .wb_we    (state == ST_WB),
    .wb_hi    (unit_div ? div_hi : mult_hi),
    .wb_lo    (unit_div ? div_lo : mult_lo),
    .mt_hi_we (idle_start && op == OP_MTHI),
    .mt_lo_we (idle_start && op == OP_MTLO),
    .mt_data  (op_a),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with interval-based reference model and unit stand-ins.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int MIN_M = 33;
  localparam int MIN_D = 33;
  localparam int MAXC  = 63;
  localparam int BIG   = 1 << 30;
  localparam int K_NONE = 0, K_MULT = 1, K_DIV = 2, K_DZ = 3, K_MTHI = 4, K_MTLO = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        op_start = 1'b0;
  logic [1:0]  op_sel = 2'b00;
  logic [31:0] op_a = '0, op_b = '0;
  logic [31:0] unit_a, unit_b, mult_hi, mult_lo, div_hi, div_lo, hi, lo;
  logic        mult_reset, mult_ctrl, mult_done, div_reset, div_ctrl, div_done;
  logic        busy, done, div_zero, timeout;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_sel(op_sel),
    .op_a(op_a), .op_b(op_b), .unit_a(unit_a), .unit_b(unit_b),
    .mult_reset(mult_reset), .mult_ctrl(mult_ctrl), .mult_done(mult_done),
    .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_reset(div_reset), .div_ctrl(div_ctrl), .div_done(div_done),
    .div_hi(div_hi), .div_lo(div_lo),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero), .timeout(timeout)
  );

  // Unit stand-ins: done after 'lat' enabled cycles since the last unit reset
  int mult_lat = 32, div_lat = 32;
  bit mult_stale = 1'b0, mult_tie0 = 1'b0;
  int mcnt = 0, dcnt = 0;
  logic [63:0] prod;
  always @(posedge clk) begin
    if (mult_reset) mcnt <= 0; else if (mult_ctrl) mcnt <= mcnt + 1;
    if (div_reset) dcnt <= 0; else if (div_ctrl) dcnt <= dcnt + 1;
  end
  assign mult_done = mult_stale || (!mult_tie0 && (mcnt >= mult_lat));
  assign div_done  = (dcnt >= div_lat);
  assign prod      = 64'(unit_a) * 64'(unit_b);
  assign mult_hi   = prod[63:32];
  assign mult_lo   = prod[31:0];
  assign div_lo    = (unit_b != 0) ? unit_a / unit_b : 32'h0;
  assign div_hi    = (unit_b != 0) ? unit_a % unit_b : 32'h0;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int errors = 0;
  int checks = 0;

  function automatic void chk1(input string name, input int e, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0b expected=%0b", name, e, act, exp);
    end
  endfunction

  function automatic void chk32(input string name, input int e, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%h expected=%h", name, e, act, exp);
    end
  endfunction

  function automatic void chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Model: the last issued op as an interval of edges, plus the values it left behind
  int          m_kind = K_NONE;
  int          m_s = 0, m_k = 0;
  bit          m_tmo = 1'b0;
  logic [31:0] m_a = '0, m_b = '0, m_hi_new = '0, m_lo_new = '0;
  logic [31:0] prev_hi = '0, prev_lo = '0;
  bit          prev_tmo = 1'b0;

  function automatic bit is_unit();
    return (m_kind == K_MULT) || (m_kind == K_DIV);
  endfunction
  function automatic bit x_busy(input int e);
    return is_unit() && e >= m_s && e <= m_s + m_k + (m_tmo ? 0 : 1);
  endfunction
  function automatic bit x_ctrl(input int e, input int kind);
    return (m_kind == kind) && e >= m_s + 1 && e <= m_s + m_k;
  endfunction
  function automatic bit x_ureset(input int e, input int kind);
    return (m_kind == kind) && e == m_s;
  endfunction
  function automatic bit x_done(input int e);
    return is_unit() && !m_tmo && e == m_s + m_k + 2;
  endfunction
  function automatic bit x_dz(input int e);
    return (m_kind == K_DZ) && e == m_s;
  endfunction
  function automatic bit x_tmo(input int e);
    if (!is_unit() || e < m_s) return prev_tmo;
    return m_tmo && e >= m_s + m_k + 1;
  endfunction
  function automatic logic [31:0] x_hi(input int e);
    if (m_kind == K_MTHI && e >= m_s) return m_a;
    if (is_unit() && !m_tmo && e >= m_s + m_k + 2) return m_hi_new;
    return prev_hi;
  endfunction
  function automatic logic [31:0] x_lo(input int e);
    if (m_kind == K_MTLO && e >= m_s) return m_a;
    if (is_unit() && !m_tmo && e >= m_s + m_k + 2) return m_lo_new;
    return prev_lo;
  endfunction

  task automatic model_start(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
    int ready;
    int min_c;
    logic [63:0] p;
    prev_hi  = x_hi(BIG);
    prev_lo  = x_lo(BIG);
    prev_tmo = x_tmo(BIG);
    m_s = edges + 1; m_a = a; m_b = b; m_tmo = 1'b0; m_k = 0;
    ready = 0; min_c = 0;
    case (sel)
      2'b00: begin
        m_kind = K_MULT; p = 64'(a) * 64'(b);
        m_hi_new = p[63:32]; m_lo_new = p[31:0];
        ready = mult_stale ? 1 : (mult_tie0 ? BIG : mult_lat + 1);
        min_c = MIN_M;
      end
      2'b01: begin
        if (b == 0) m_kind = K_DZ;
        else begin
          m_kind = K_DIV; m_hi_new = a % b; m_lo_new = a / b;
          ready = div_lat + 1; min_c = MIN_D;
        end
      end
      2'b10: m_kind = K_MTHI;
      default: m_kind = K_MTLO;
    endcase
    m_k = (ready > min_c) ? ready : min_c;
    if (m_k > MAXC) begin m_tmo = 1'b1; m_k = MAXC; end
  endtask

  task automatic model_clear();
    m_kind = K_NONE; prev_hi = '0; prev_lo = '0; prev_tmo = 1'b0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    int e;
    e = edges;
    chk1("busy", e, busy, x_busy(e));
    chk1("done", e, done, x_done(e));
    chk1("div_zero", e, div_zero, x_dz(e));
    chk1("timeout", e, timeout, x_tmo(e));
    chk1("mult_reset", e, mult_reset, x_ureset(e, K_MULT));
    chk1("div_reset", e, div_reset, x_ureset(e, K_DIV));
    chk1("mult_ctrl", e, mult_ctrl, x_ctrl(e, K_MULT));
    chk1("div_ctrl", e, div_ctrl, x_ctrl(e, K_DIV));
    chk32("hi", e, hi, x_hi(e));
    chk32("lo", e, lo, x_lo(e));
    if (x_busy(e)) begin
      chk32("unit_a", e, unit_a, m_a);
      chk32("unit_b", e, unit_b, m_b);
    end
  end

  // Drive one request; s is the clock edge that samples it
  task automatic issue(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input bit modeled, output int s);
    @(posedge clk); #1;
    s = edges + 1;
    if (modeled) model_start(sel, a, b);
    op_start = 1'b1; op_sel = sel; op_a = a; op_b = b;
    @(posedge clk); #1;
    op_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int s, output int lat);
    bit found;
    found = 1'b0;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin lat = edges - s; found = 1'b1; break; end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s_wait done not seen within 100 cycles", name);
    end
  endtask

  initial begin : main
    int s, s2, lat;
    repeat (3) @(negedge clk);
    chk32("rst_hi", edges, hi, 32'h0);
    chk32("rst_lo", edges, lo, 32'h0);
    chk1("rst_busy", edges, busy, 1'b0);
    chk1("rst_mult_ctrl", edges, mult_ctrl, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk32("post_rst_lo", edges, lo, 32'h0);

    issue(2'b00, 32'h0000_FFFF, 32'h0001_0000, 1'b1, s);
    wait_done("mult", s, lat);
    chk_int("mult_latency", lat, 35);
    chk32("mult_hi", edges, hi, 32'h0000_0000);
    chk32("mult_lo", edges, lo, 32'hFFFF_0000);
    $display("MULT ffff*10000 latency=%0d hi=%h lo=%h", lat, hi, lo);

    mult_stale = 1'b1;
    issue(2'b00, 32'd3, 32'd5, 1'b1, s);
    wait_done("stale", s, lat);
    chk_int("stale_latency", lat, 35);
    chk32("stale_lo", edges, lo, 32'd15);
    chk32("stale_hi", edges, hi, 32'd0);
    mult_stale = 1'b0;
    $display("MULT 3*5 stale done latency=%0d hi=%h lo=%h", lat, hi, lo);

    issue(2'b01, 32'd7, 32'd0, 1'b1, s);
    @(negedge clk);
    chk1("dz_pulse", edges, div_zero, 1'b1);
    repeat (2) @(negedge clk);
    chk32("dz_lo", edges, lo, 32'd15);
    $display("DIV 7/0 div_zero seen, lo=%h", lo);

    issue(2'b01, 32'd7, 32'd2, 1'b1, s);
    wait_done("div", s, lat);
    chk32("div_lo", edges, lo, 32'd3);
    chk32("div_hi", edges, hi, 32'd1);
    $display("DIV 7/2 latency=%0d hi=%h lo=%h", lat, hi, lo);

    issue(2'b10, 32'hDEAD_BEEF, 32'h0, 1'b1, s);
    @(negedge clk);
    chk32("mthi", edges, hi, 32'hDEAD_BEEF);
    $display("MTHI hi=%h", hi);
    issue(2'b11, 32'h0000_1234, 32'h0, 1'b1, s);
    @(negedge clk);
    chk32("mtlo", edges, lo, 32'h0000_1234);
    $display("MTLO lo=%h", lo);

    mult_tie0 = 1'b1;
    issue(2'b00, 32'd9, 32'd9, 1'b1, s);
    repeat (MAXC + 3) @(negedge clk);
    chk1("tmo_flag", edges, timeout, 1'b1);
    chk32("tmo_hi", edges, hi, 32'hDEAD_BEEF);
    $display("MULT with dead unit: timeout=%0b hi=%h", timeout, hi);
    mult_tie0 = 1'b0;

    mult_lat = 40;
    issue(2'b00, 32'd2, 32'd3, 1'b1, s);
    chk1("tmo_cleared", edges, timeout, 1'b0);
    wait_done("slow", s, lat);
    chk_int("slow_latency", lat, 43);
    chk32("slow_lo", edges, lo, 32'd6);
    mult_lat = 32;
    $display("MULT 2*3 slow unit latency=%0d lo=%h", lat, lo);

    issue(2'b00, 32'd4, 32'd4, 1'b1, s);
    repeat (10) @(negedge clk);
    issue(2'b01, 32'd100, 32'd3, 1'b0, s2);
    wait_done("ignored", s, lat);
    chk32("ign_lo", edges, lo, 32'd16);
    chk32("ign_hi", edges, hi, 32'd0);
    $display("MULT 4*4 with DIV during RUN ignored: hi=%h lo=%h", hi, lo);

    issue(2'b00, 32'd5, 32'd5, 1'b1, s);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    #1;
    chk1("midrst_busy", edges, busy, 1'b0);
    chk1("midrst_ctrl", edges, mult_ctrl, 1'b0);
    $display("Reset mid-RUN: busy=%0b mult_ctrl=%0b", busy, mult_ctrl);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
